muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_seq.sv | 151 +++++++++++++++
 tb/tb_muldiv_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit: op select and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Division ops all have the top funct3 bit set.
  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: {hi,lo} holds partial product / multiplier, shifted right each step.
  // Divide: {hi,lo} holds partial remainder / dividend-quotient, shifted left each step.
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_nxt  = sum[WIDTH:1];
    lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (shifted >= {1'b0, opnd}) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one bit per cycle on magnitudes, sign fix-up at the end.
// Latency: done WIDTH+2 cycles after start; divide-by-zero and signed overflow finish in 1.
// Backpressure: raises StallE while busy; FlushE abandons the op silently.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             FlushE,
  output logic             StallE,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t state, state_nxt;
  muldiv_op_t    op_in, op_q;
  logic [CW-1:0] cnt;
  logic          sign_a_q, sign_b_q;
  logic [WIDTH-1:0] hi, lo, opnd, hi_nxt, lo_nxt;

  // Input decode: signedness, magnitudes and the two short-circuit cases.
  logic div_in, a_sgn, b_sgn, sa, sb, div_zero, div_ovf, special, accept;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  assign op_in       = muldiv_op_t'(funct3);
  assign div_in      = op_is_div(op_in);
  assign a_sgn       = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn       = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign sa          = SrcA[WIDTH-1] & a_sgn;
  assign sb          = SrcB[WIDTH-1] & b_sgn;
  assign mag_a       = sa ? -SrcA : SrcA;
  assign mag_b       = sb ? -SrcB : SrcB;
  assign div_zero    = div_in && (SrcB == '0);
  assign div_ovf     = div_in && b_sgn && (SrcA == MOST_NEG) && (SrcB == '1);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (funct3[1] ? SrcA : '1) : (funct3[1] ? '0 : SrcA);
  assign accept      = (state == IDLE) && start && !FlushE;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div(op_q)),
    .hi     (hi),
    .lo     (lo),
    .opnd   (opnd),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Sign fix-up and field select applied to the finished magnitudes.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quot_fix = (sign_a_q ^ sign_b_q) ? -lo : lo;
    rem_fix  = sign_a_q ? -hi : hi;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = quot_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    StallE    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !FlushE) begin
          StallE    = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        StallE = 1'b1;
        if (FlushE)          state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = FIX;
      end
      FIX: begin
        StallE    = 1'b1;
        state_nxt = FlushE ? IDLE : DONE;
      end
      DONE: begin
        done      = !FlushE;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) StallE = 1'b0;
  end

  // Operand latch, iteration registers, counter and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= op_in;
            sign_a_q <= sa;
            sign_b_q <= sb;
            cnt      <= '0;
            hi       <= '0;
            lo       <= div_in ? mag_a : mag_b;
            opnd     <= div_in ? mag_b : mag_a;
            if (special) result <= special_res;
          end
        end
        CALC: begin
          if (!FlushE) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!FlushE) result <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed spec vectors, random ops vs a reference model,
// flush / reset abandonment, back-to-back ops and start ignored while busy.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_muldiv_seq;

  logic        clk, reset, start, FlushE, StallE, done;
  logic [2:0]  funct3;
  logic [31:0] SrcA, SrcB, result;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .FlushE (FlushE),
    .StallE (StallE),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Issue one op; returns result at done, cycles with StallE high, and the done cycle
  // (start cycle = 1, 0 = no done within budget). scramble keeps start high with junk operands.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, output logic [31:0] res, output int stalls,
                       output int done_c);
    @(negedge clk);
    funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
    stalls = 0; done_c = 0; res = '0;
    for (int c = 1; c <= 80; c++) begin
      #1;
      if (StallE === 1'b1) stalls++;
      if (done === 1'b1) begin
        done_c = c;
        res = result;
        break;
      end
      @(negedge clk);
      if (scramble) begin
        SrcA = $urandom; SrcB = $urandom; funct3 = 3'($urandom_range(0, 7)); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; FlushE = 1'b0;
    funct3 = 3'b100; SrcA = 32'd5; SrcB = 32'd1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (StallE !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", StallE); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    bit          spec;
  } vec_t;

  vec_t vecs [10] = '{
    '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
    '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
    '{3'b111, 32'h00000007, 32'h00000003, 32'h00000001, 1'b0},
    '{3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1},
    '{3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1},
    '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
    '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},
    '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
    '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0},
    '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}
  };

  task automatic test_directed();
    logic [31:0] res;
    int stalls, done_c;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, res, stalls, done_c);
      n_tests++;
      if (res !== vecs[i].exp) begin
        n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, vecs[i].exp);
      end
      n_tests++;
      if (done_c != (vecs[i].spec ? 2 : 35)) begin
        n_fail++; $display("FAIL directed_done_cycle[%0d]: got %0d expected %0d", i, done_c, vecs[i].spec ? 2 : 35);
      end
      n_tests++;
      if (stalls != (vecs[i].spec ? 1 : 34)) begin
        n_fail++; $display("FAIL directed_stall_cycles[%0d]: got %0d expected %0d", i, stalls, vecs[i].spec ? 1 : 34);
      end
      // done is a single-cycle pulse and result holds afterwards
      @(negedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || result !== vecs[i].exp) begin
        n_fail++; $display("FAIL directed_after_done[%0d]: got done=%b result=%h expected done=0 result=%h", i, done, result, vecs[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [2:0]  f;
    int stalls, done_c, mode, exp_c;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      a = $urandom; b = $urandom;
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (mode == 2) begin
        a = $urandom_range(0, 20); b = $urandom_range(1, 7);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      exp = ref_model(f, a, b);
      exp_c = is_special(f, a, b) ? 2 : 35;
      do_op(f, a, b, (i % 4) == 3, res, stalls, done_c);
      n_tests++;
      if (res !== exp) begin
        n_fail++; $display("FAIL random_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp);
      end
      n_tests++;
      if (done_c != exp_c) begin
        n_fail++; $display("FAIL random_done_cycle[%0d]: got %0d expected %0d", i, done_c, exp_c);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int stalls, done_c;
    do_op(3'b011, 32'hDEADBEEF, 32'h00001234, 1'b0, prev, stalls, done_c);
    // flush beats a simultaneous start in IDLE
    @(negedge clk);
    funct3 = 3'b100; SrcA = 32'd100; SrcB = 32'd3; start = 1'b1; FlushE = 1'b1;
    #1;
    n_tests++;
    if (StallE !== 1'b0) begin n_fail++; $display("FAIL flush_vs_start_stall: got %b expected 0", StallE); end
    @(negedge clk);
    start = 1'b0; FlushE = 1'b0;
    #1;
    n_tests++;
    if (StallE !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL flush_vs_start_idle: got stall=%b done=%b expected 0/0", StallE, done);
    end
    // flush in CALC cycle 10 (overall cycle 11)
    @(negedge clk);
    funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd7; start = 1'b1;
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    FlushE = 1'b1;
    #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL flush_calc_done: got %b expected 0", done); end
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    n_tests++;
    if (StallE !== 1'b0 || done !== 1'b0 || result !== prev) begin
      n_fail++; $display("FAIL flush_calc_idle: got stall=%b done=%b result=%h expected 0/0/%h", StallE, done, result, prev);
    end
    // immediate restart completes normally
    do_op(3'b110, 32'hFFFFF000, 32'h00000033, 1'b0, res, stalls, done_c);
    n_tests++;
    if (res !== ref_model(3'b110, 32'hFFFFF000, 32'h00000033) || done_c != 35) begin
      n_fail++; $display("FAIL flush_restart: got %h at cycle %0d expected %h at cycle 35", res, done_c, ref_model(3'b110, 32'hFFFFF000, 32'h00000033));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] prev;
    int stalls, done_c, seen;
    do_op(3'b000, 32'h00012345, 32'h00000011, 1'b0, prev, stalls, done_c);
    @(negedge clk);
    funct3 = 3'b101; SrcA = 32'hABCDEF01; SrcB = 32'd9; start = 1'b1;
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1; start = 1'b1;
    #1;
    n_tests++;
    if (StallE !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall: got %b expected 0", StallE); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    #1;
    n_tests++;
    if (result !== 32'h0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state: got result=%h done=%b expected 0/0", result, done);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1 || StallE === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid_abandon: got %0d busy/done cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3] = '{32'hFFFFFFF9, 32'h7FFFFFFF, 32'hC0000001};
    logic [31:0] b [3] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000005};
    logic [2:0]  f [3] = '{3'b100, 3'b010, 3'b110};
    logic [31:0] res;
    int stalls, done_c;
    for (int i = 0; i < 3; i++) begin
      do_op(f[i], a[i], b[i], i == 1, res, stalls, done_c);
      n_tests++;
      if (res !== ref_model(f[i], a[i], b[i]) || done_c != 35) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %h at cycle %0d expected %h at cycle 35", i, res, done_c, ref_model(f[i], a[i], b[i]));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    start = 1'b0; FlushE = 1'b0; reset = 1'b1;
    funct3 = '0; SrcA = '0; SrcB = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
